ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
- Game-sequencing controller for the 3x3 tic-tac-toe board shown on the four-digit seven-segment display.
- Takes two debounced pushbutton levels (NEXT and PLACE) and maintains the board, the cursor, the player turn and the winner state.
- Drives the pos1..pos9, win and player inputs of the board display driver directly.
- Cell codes match the driver: 0 = blank, 1 = solid (player 1), 2 = blinking (player 2).

Parameters:
- CURSOR_DIV, 25000000: CLK cycles per cursor blink phase toggle. Must be at least 1. Use a small value in simulation.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- BTN_NEXT  in  1  debounced level; a rising edge moves the cursor.
- BTN_PLACE  in  1  debounced level; a rising edge places a mark, or restarts when the game is over.
- pos1..pos9  out  2 each  displayed cell codes, cursor overlay included.
- win  out  2  0 = none, 1 = player 1 won, 2 = player 2 won, 3 = draw (only with the optional feature).
- player  out  1  0 = player 1 to move, 1 = player 2 to move.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high. On CLK, when RST is high, reset takes effect.
  - RST takes priority over every other event, including mid-CHECK and in OVER.
  - Reset values: board all 0, cursor = 0 (pos1), player = 0, win = 0, state = PLAY, blink phase = 0, blink counter = 0, button history = 0.
- Edge detection:
  - Each button is registered once; edge = level & ~previous level.
  - A held button produces exactly one edge.
  - NEXT and PLACE edges in the same cycle: PLACE wins and NEXT is discarded.
- State PLAY:
  - NEXT edge: cursor moves to the next empty cell in ascending index order, wrapping from 8 to 0. If no other cell is empty, the cursor stays.
  - PLACE edge: the cell at the cursor gets code player+1 (visible on the next cycle), then state goes to CHECK. The cursor always sits on an empty cell, so PLACE is always legal.
- State CHECK (exactly 1 cycle):
  - Evaluate the 8 lines: rows 012, 345, 678; columns 036, 147, 258; diagonals 048, 246.
  - A line of the mover's code: win = mover's code, go to OVER.
  - Else, board full: handled per the optional feature.
  - Else: toggle player, move the cursor to the first empty cell at or after cursor+1 (wrapping), go to PLAY.
  - Latency: PLACE edge in cycle n; board updated at n+1; win/player/cursor updated at n+2.
- State OVER:
  - Board, win and player are frozen. NEXT is ignored. No cursor overlay.
  - PLACE edge: board cleared, win = 0, player = 0, cursor = 0, go to PLAY on the next cycle.
- Cursor overlay (PLAY only):
  - The cursor cell outputs player+1 when the blink phase is 1, and 0 when it is 0.
  - The blink counter counts 0..CURSOR_DIV-1. On wrap, the phase toggles.
  - The counter runs freely in all states and is cleared only by RST.
  - All other cells output their board code.
- Output timing: all outputs are registered or driven from registers only; no combinational path from the buttons to the outputs.

Optional Feature:
- Macro: TTT_DRAW_DETECT_EN.
- Defined: a full board with no winner sets win = 3 (the display blanks) and goes to OVER.
- Undefined: a full board with no winner goes to OVER with win = 0, so the final board stays visible. PLACE restarts in both cases.

Decomposition:
- Package ttt_pkg:
  - Cell codes (CELL_EMPTY/P1/P2).
  - Win codes (WIN_NONE/P1/P2/DRAW).
  - State enum (PLAY, CHECK, OVER).
  - Constant table of the 8 winning index triples.
- Sub-module ttt_line_check: combinational. Inputs are the 9x2 board and the mover's code. Outputs are line_hit, board_full and the next-empty-cell index from a given start.

Test Plan:
- Reset, then CURSOR_DIV=4 -> win=0, player=0, all cells 0 except pos1, which toggles 0/1 every 4 cycles.
- PLACE edge at cursor 0 -> pos1=1 at n+1; player=1 and cursor=1 at n+2. Then two NEXT edges -> cursor=3 (pos4 blinks 0/2).
- Moves P1:0, P2:3, P1:1, P2:4, P1:2 -> win=1 two cycles after the last PLACE edge; pos1..3=1, pos4,5=2; further NEXT/PLACE-free cycles keep everything frozen.
- In OVER, PLACE edge -> all pos 0, win=0, player=0, cursor=0, state PLAY next cycle.
- Draw sequence 0,1,2,4,3,5,7,6,8 -> win=3 with TTT_DRAW_DETECT_EN; win=0 and board held without it.
- NEXT+PLACE rising together -> place only. PLACE held 20 cycles -> one mark. RST asserted during CHECK -> reset values next cycle.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared cell/win codes, FSM state type and the winning-line table for the
// tic-tac-toe game controller.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [3:0] wrap_inc(input logic [3:0] idx);
    return (idx == 4'd8) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational board evaluation: line hit for the mover, board-full flag and
// the first empty cell at or after a start index (wrapping 8 -> 0).
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0][1:0] board,
  input  logic [1:0]      mover,
  input  logic [3:0]      start,
  output logic            line_hit,
  output logic            board_full,
  output logic [3:0]      next_empty
);

  always_comb begin
    line_hit = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (board[WIN_LINES[l][0]] == mover &&
          board[WIN_LINES[l][1]] == mover &&
          board[WIN_LINES[l][2]] == mover)
        line_hit = 1'b1;
    end
  end

  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < 9; i++)
      if (board[i] == CELL_EMPTY) board_full = 1'b0;
  end

  // Falls back to start itself when nothing is empty.
  always_comb begin
    logic       found;
    logic [4:0] sum;
    logic [3:0] idx;
    found      = 1'b0;
    next_empty = start;
    sum        = 5'd0;
    idx        = 4'd0;
    for (int k = 0; k < 9; k++) begin
      sum = {1'b0, start} + 5'(k);
      if (sum > 5'd8) sum = sum - 5'd9;
      idx = sum[3:0];
      if (!found && board[idx] == CELL_EMPTY) begin
        next_empty = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer driving the seven-segment board display.
// Build option: define TTT_DRAW_DETECT_EN to report a full board as win = 3.
//
// state | meaning
// PLAY  | waiting for NEXT (move cursor) or PLACE (mark cell)
// CHECK | one cycle: evaluate lines for the mover, then hand over or end
// OVER  | frozen result; PLACE restarts the game
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned CURSOR_DIV = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_NEXT,
  input  logic       BTN_PLACE,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] win,
  output logic       player
);

  localparam int CW = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;

  state_t          state;
  logic [8:0][1:0] board;
  logic [3:0]      cursor;
  logic [CW-1:0]   blink_cnt;
  logic            blink;
  logic            next_q, place_q;
  logic            next_edge, place_edge;
  logic [1:0]      mover;
  logic            line_hit, board_full;
  logic [3:0]      next_empty;
  logic [1:0]      disp [9];

  assign next_edge  = BTN_NEXT & ~next_q;
  assign place_edge = BTN_PLACE & ~place_q;
  assign mover      = player ? CELL_P2 : CELL_P1;

  ttt_line_check u_line_check (
    .board      (board),
    .mover      (mover),
    .start      (wrap_inc(cursor)),
    .line_hit   (line_hit),
    .board_full (board_full),
    .next_empty (next_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= PLAY;
      board     <= '0;
      cursor    <= 4'd0;
      player    <= 1'b0;
      win       <= WIN_NONE;
      blink_cnt <= '0;
      blink     <= 1'b0;
      next_q    <= 1'b0;
      place_q   <= 1'b0;
    end else begin
      next_q  <= BTN_NEXT;
      place_q <= BTN_PLACE;
      if (blink_cnt == CW'(CURSOR_DIV - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      case (state)
        PLAY: begin
          // PLACE has priority over a simultaneous NEXT.
          if (place_edge) begin
            board[cursor] <= mover;
            state         <= CHECK;
          end else if (next_edge) begin
            cursor <= next_empty;
          end
        end
        CHECK: begin
          if (line_hit) begin
            win   <= player ? WIN_P2 : WIN_P1;
            state <= OVER;
          end else if (board_full) begin
`ifdef TTT_DRAW_DETECT_EN
            win   <= WIN_DRAW;
`endif
            state <= OVER;
          end else begin
            player <= ~player;
            cursor <= next_empty;
            state  <= PLAY;
          end
        end
        OVER: begin
          if (place_edge) begin
            board  <= '0;
            win    <= WIN_NONE;
            player <= 1'b0;
            cursor <= 4'd0;
            state  <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      disp[i] = board[i];
      if (state == PLAY && cursor == 4'(i))
        disp[i] = blink ? mover : CELL_EMPTY;
    end
  end

  assign pos1 = disp[0];
  assign pos2 = disp[1];
  assign pos3 = disp[2];
  assign pos4 = disp[3];
  assign pos5 = disp[4];
  assign pos6 = disp[5];
  assign pos7 = disp[6];
  assign pos8 = disp[7];
  assign pos9 = disp[8];

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl with a short blink period.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_NEXT = 1'b0;
  logic       BTN_PLACE = 1'b0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] win;
  logic       player;

  int n_checks = 0;
  int n_fail   = 0;

  ttt_game_ctrl #(.CURSOR_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .BTN_NEXT(BTN_NEXT), .BTN_PLACE(BTN_PLACE),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .win(win), .player(player)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_next();
    BTN_NEXT = 1'b1; tick();
    BTN_NEXT = 1'b0; tick();
  endtask

  task automatic press_place();
    BTN_PLACE = 1'b1; tick();
    BTN_PLACE = 1'b0; tick();
  endtask

  task automatic place_at(input int target);
    for (int i = 0; i < 9; i++)
      if (int'(dut.cursor) != target) press_next();
    check("cursor_reach", int'(dut.cursor), target);
    press_place();
  endtask

  function automatic int cells(input int i);
    logic [1:0] p [9];
    p = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
    return int'(p[i]);
  endfunction

  initial begin
    int seen;
    int exp_draw [9];

    // Reset and cursor blink on pos1
    tick(); tick();
    RST = 1'b0;
    check("rst_win", win, 0);
    check("rst_player", player, 0);
    for (int i = 1; i < 9; i++) check($sformatf("rst_pos%0d", i + 1), cells(i), 0);
    for (int j = 0; j < 9; j++) begin
      check($sformatf("blink_j%0d", j), pos1, (j / 4) % 2);
      tick();
    end

    // First placement and latency
    BTN_PLACE = 1'b1; tick();
    check("place_n1_board", dut.board[0], 1);
    check("place_n1_state", int'(dut.state), int'(CHECK));
    check("place_n1_player", player, 0);
    BTN_PLACE = 1'b0; tick();
    check("place_n2_player", player, 1);
    check("place_n2_cursor", int'(dut.cursor), 1);
    check("place_n2_pos1", pos1, 1);
    press_next();
    press_next();
    check("next2_cursor", int'(dut.cursor), 3);
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      seen |= (1 << pos4);
      tick();
    end
    check("pos4_blink_set", seen, 5);

    // Win by P1 on the top row
    place_at(3);
    check("p2_at3_cursor", int'(dut.cursor), 4);
    place_at(1);
    place_at(4);
    for (int i = 0; i < 9; i++)
      if (int'(dut.cursor) != 2) press_next();
    BTN_PLACE = 1'b1; tick();
    check("win_n1_win", win, 0);
    BTN_PLACE = 1'b0; tick();
    check("win_n2_win", win, 1);
    check("win_player", player, 0);
    check("win_state", int'(dut.state), int'(OVER));
    for (int k = 0; k < 10; k++) begin
      if (k == 3) BTN_NEXT = 1'b1;
      if (k == 4) BTN_NEXT = 1'b0;
      tick();
    end
    check("frozen_win", win, 1);
    check("frozen_player", player, 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("frozen_pos%0d", i + 1), cells(i), (i < 3) ? 1 : (i < 5) ? 2 : 0);

    // Restart from OVER
    BTN_PLACE = 1'b1; tick();
    check("restart_state", int'(dut.state), int'(PLAY));
    check("restart_win", win, 0);
    check("restart_player", player, 0);
    check("restart_cursor", int'(dut.cursor), 0);
    check("restart_board", int'(dut.board), 0);
    for (int i = 1; i < 9; i++) check($sformatf("restart_pos%0d", i + 1), cells(i), 0);
    BTN_PLACE = 1'b0; tick();

    // Draw sequence
    place_at(0); place_at(1); place_at(2); place_at(4); place_at(3);
    place_at(5); place_at(7); place_at(6); place_at(8);
    exp_draw = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
`ifdef TTT_DRAW_DETECT_EN
    check("draw_win", win, 3);
`else
    check("draw_win", win, 0);
`endif
    check("draw_state", int'(dut.state), int'(OVER));
    check("draw_player", player, 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("draw_pos%0d", i + 1), cells(i), exp_draw[i]);
    press_place();
    check("draw_restart_state", int'(dut.state), int'(PLAY));
    check("draw_restart_win", win, 0);

    // NEXT and PLACE together: place only
    BTN_NEXT = 1'b1; BTN_PLACE = 1'b1; tick();
    check("both_state", int'(dut.state), int'(CHECK));
    check("both_cursor", int'(dut.cursor), 0);
    check("both_pos1", pos1, 1);
    BTN_NEXT = 1'b0; BTN_PLACE = 1'b0; tick();
    check("both_after_cursor", int'(dut.cursor), 1);
    check("both_after_player", player, 1);

    // PLACE held for 20 cycles produces one mark
    BTN_PLACE = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    BTN_PLACE = 1'b0; tick();
    check("held_board", int'(dut.board), (2 << 2) | 1);
    check("held_player", player, 0);
    check("held_cursor", int'(dut.cursor), 2);

    // RST during CHECK
    BTN_PLACE = 1'b1; tick();
    check("rstchk_pre_state", int'(dut.state), int'(CHECK));
    BTN_PLACE = 1'b0; RST = 1'b1; tick();
    check("rstchk_state", int'(dut.state), int'(PLAY));
    check("rstchk_board", int'(dut.board), 0);
    check("rstchk_player", player, 0);
    check("rstchk_win", win, 0);
    check("rstchk_cursor", int'(dut.cursor), 0);
    check("rstchk_blink", int'(dut.blink), 0);
    RST = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
